// File: rtl/lut_or_pkg.sv
// Shared definitions for the round-robin OR arbiter: id width helper and
// the legal range of requester counts.
package lut_or_pkg;

    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 8;

    // A single requester index still needs one bit, hence the floor of 1.
    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit n_req_legal(input int n);
        return (n >= N_REQ_MIN) && (n <= N_REQ_MAX);
    endfunction

endpackage

// File: rtl/lut_or_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// searching upward with wrap, returned as one-hot grant plus encoded index.
module rr_pick
    import lut_or_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx
);

    logic [IDW:0] cand;
    logic         found;

    // One extra bit on the candidate so ptr + offset cannot overflow before the wrap.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        if (enable) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand = {1'b0, ptr} + (IDW+1)'(i);
                if (cand >= (IDW+1)'(N_REQ)) begin
                    cand = cand - (IDW+1)'(N_REQ);
                end
                if (!found && req[cand[IDW-1:0]]) begin
                    found                 = 1'b1;
                    gnt[cand[IDW-1:0]]    = 1'b1;
                    idx                   = cand[IDW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/lut_or_arbiter.sv
// Round-robin arbiter sharing one registered OR stage among N_REQ requesters,
// with a single-entry valid/ready output register.
module lut_or_arbiter
    import lut_or_pkg::*;
#(
    parameter  int N_REQ = 3,
    parameter  int W     = 1,
    localparam int IDW   = calc_idw(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ*W-1:0] a,
    input  logic [N_REQ*W-1:0] b,
    output logic [N_REQ-1:0] gnt,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic [W-1:0]     res_data,
    input  logic             out_ready
);

    if (!n_req_legal(N_REQ)) begin : g_bad_n_req
        $error("lut_or_arbiter: N_REQ out of range");
    end

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   pick_idx;
    logic [N_REQ-1:0] pick_gnt;
    logic             ready;
    logic             granted;
    logic [W-1:0]     or_data;

    // Reset gates the picker so a request during reset is never granted.
    assign ready = !rst && en && (!res_valid || out_ready);

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .enable (ready),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    assign gnt     = pick_gnt;
    assign granted = |pick_gnt;
    assign or_data = a[pick_idx*W +: W] | b[pick_idx*W +: W];

    // A grant refills the output register even while the old result drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else if (granted) begin
            res_valid <= 1'b1;
            res_id    <= pick_idx;
            res_data  <= or_data;
            ptr       <= (pick_idx == IDW'(N_REQ-1)) ? '0 : pick_idx + IDW'(1);
        end else if (out_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_or_arbiter.sv
// Self-checking bench for lut_or_arbiter: directed scenarios plus a random
// run checked against a reference model and result scoreboard.
module tb_lut_or_arbiter;

    localparam int N   = 3;
    localparam int W   = 1;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0]   gnt;
    logic           res_valid;
    logic [IDW-1:0] res_id;
    logic [W-1:0]   res_data;
    logic           out_ready;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lut_or_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .a         (a),
        .b         (b),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .out_ready (out_ready)
    );

    // Reference round-robin choice, independent of the RTL structure.
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input int p, input bit rdy);
        logic [N-1:0] g;
        g = '0;
        if (rdy) begin
            for (int i = 0; i < N; i++) begin
                if (g == '0 && r[(p + i) % N]) g[(p + i) % N] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [W-1:0] or_of(input int k);
        return a[k*W +: W] | b[k*W +: W];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = '1; out_ready = 1'b1; a = '0; b = '0;
        @(negedge clk);
        compared++;
        if (gnt !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_gnt_in_reset: got %b expected 000", gnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (gnt !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_gnt_held: got %b expected 000", gnt);
        end
        compared++;
        if ({res_valid, res_id, res_data} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got valid=%b id=%0d data=%b expected all zero",
                     res_valid, res_id, res_data);
        end
        req = '0; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_gnt [4];
        int           exp_id  [4];
        exp_t         e;
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_id  = '{0, 1, 2, 0};
        req = 3'b111; en = 1'b1; out_ready = 1'b1; a = 3'b001; b = 3'b000;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) req = '0;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compared++;
                if (res_valid !== 1'b1 || res_id !== e.id || res_data !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL rr_result[%0d]: got valid=%b id=%0d data=%b expected valid=1 id=%0d data=%b",
                             i, res_valid, res_id, res_data, e.id, e.data);
                end
            end
            compared++;
            if (i < 4 && gnt !== exp_gnt[i]) begin
                mismatched++;
                $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp_gnt[i]);
            end else if (i == 4 && gnt !== '0) begin
                mismatched++;
                $display("[TB] FAIL rr_gnt_idle: got %b expected 000", gnt);
            end
            if (i < 4) sb.push_back('{id: IDW'(exp_id[i]), data: or_of(exp_id[i])});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lone_requester();
        exp_t e;
        req = 3'b010; a = 3'b010; b = 3'b000;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) a = 3'b000;
            if (i == 5) req = '0;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compared++;
                if (res_valid !== 1'b1 || res_id !== e.id || res_data !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL lone_result[%0d]: got valid=%b id=%0d data=%b expected valid=1 id=%0d data=%b",
                             i, res_valid, res_id, res_data, e.id, e.data);
                end
            end
            compared++;
            if (i < 5 && gnt !== 3'b010) begin
                mismatched++;
                $display("[TB] FAIL lone_gnt[%0d]: got %b expected 010", i, gnt);
            end else if (i == 5 && gnt !== '0) begin
                mismatched++;
                $display("[TB] FAIL lone_gnt_idle: got %b expected 000", gnt);
            end
            if (i < 5) sb.push_back('{id: IDW'(1), data: or_of(1)});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 3'b111; out_ready = 1'b1; a = '0; b = '0;
        @(negedge clk);
        compared++;
        if (gnt !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL bp_first_gnt: got %b expected 001", gnt);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (gnt !== '0 || res_valid !== 1'b1 || res_id !== 2'd0) begin
                mismatched++;
                $display("[TB] FAIL bp_hold[%0d]: got gnt=%b valid=%b id=%0d expected gnt=000 valid=1 id=0",
                         i, gnt, res_valid, res_id);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (gnt !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL bp_release_gnt: got %b expected 010", gnt);
        end
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        compared++;
        if (res_valid !== 1'b1 || res_id !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL bp_release_result: got valid=%b id=%0d expected valid=1 id=1", res_valid, res_id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_enable_freeze();
        do_reset();
        req = 3'b101; en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (gnt !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL en_first_gnt: got %b expected 001", gnt);
        end
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (gnt !== '0 || res_valid !== (i == 0)) begin
                mismatched++;
                $display("[TB] FAIL en_off[%0d]: got gnt=%b valid=%b expected gnt=000 valid=%0d",
                         i, gnt, res_valid, (i == 0));
            end
            @(posedge clk); #1;
        end
        en = 1'b1;
        @(negedge clk);
        compared++;
        if (gnt !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL en_resume_gnt: got %b expected 100", gnt);
        end
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        compared++;
        if (res_valid !== 1'b1 || res_id !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL en_resume_result: got valid=%b id=%0d expected valid=1 id=2", res_valid, res_id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b111; en = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (gnt !== '0 || res_valid !== 1'b1 || res_id !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_before: got gnt=%b valid=%b id=%0d expected gnt=000 valid=1 id=1",
                     gnt, res_valid, res_id);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (res_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_valid: got %b expected 0", res_valid);
        end
        compared++;
        if (gnt !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL rstmid_gnt: got %b expected 001", gnt);
        end
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        compared++;
        if (res_valid !== 1'b1 || res_id !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_result: got valid=%b id=%0d expected valid=1 id=0", res_valid, res_id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int           m_ptr;
        bit           m_valid;
        bit           rdy;
        int           k;
        int           wait_cnt [N];
        logic [N-1:0] exp_g;
        exp_t         e;
        do_reset();
        sb.delete();
        req = '0; en = 1'b1; out_ready = 1'b1;
        m_ptr = 0; m_valid = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc <= 10000; cyc++) begin
            if (cyc == 10000) req = '0;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compared++;
                if (res_valid !== 1'b1 || res_id !== e.id || res_data !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL rand_result cyc %0d: got valid=%b id=%0d data=%b expected valid=1 id=%0d data=%b",
                             cyc, res_valid, res_id, res_data, e.id, e.data);
                end
            end
            compared++;
            if (res_valid !== m_valid) begin
                mismatched++;
                $display("[TB] FAIL rand_valid cyc %0d: got %b expected %b", cyc, res_valid, m_valid);
            end
            rdy   = en && (!m_valid || out_ready);
            exp_g = model_pick(req, m_ptr, rdy);
            compared++;
            if (gnt !== exp_g) begin
                mismatched++;
                $display("[TB] FAIL rand_gnt cyc %0d: got %b expected %b", cyc, gnt, exp_g);
            end
            compared++;
            if (!$onehot0(gnt)) begin
                mismatched++;
                $display("[TB] FAIL rand_onehot cyc %0d: got %b expected one-hot or zero", cyc, gnt);
            end
            k = -1;
            for (int i = 0; i < N; i++) if (exp_g[i]) k = i;
            if (k >= 0) begin
                sb.push_back('{id: IDW'(k), data: or_of(k)});
                for (int i = 0; i < N; i++) begin
                    if (i != k && req[i]) wait_cnt[i]++;
                end
                wait_cnt[k] = 0;
                for (int i = 0; i < N; i++) begin
                    compared++;
                    if (wait_cnt[i] > N) begin
                        mismatched++;
                        $display("[TB] FAIL rand_starve cyc %0d: requester %0d waited %0d grants, limit %0d",
                                 cyc, i, wait_cnt[i], N);
                    end
                end
            end
            @(posedge clk);
            if (k >= 0) begin
                m_valid = 1'b1;
                m_ptr   = (k == N-1) ? 0 : k + 1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            #1;
            if (k >= 0) req[k] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    a[i*W +: W] = W'($urandom);
                    b[i*W +: W] = W'($urandom);
                    req[i]      = ($urandom_range(0, 2) != 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 9) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lone_requester();
        test_backpressure();
        test_enable_freeze();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
